dmem_arbiter: RTL and testbench
===============================

Name: dmem_arbiter

Overview:
Two-port arbiter and access sequencer in front of the single-port byte-addressed data memory (9-bit address, 32-bit data, Size/RW/E/SE control).
- Requester 0 is the load/store unit; requester 1 is the debug/DMA port.
- Grants one access at a time with round-robin fairness and rejects misaligned or illegal-size accesses.
- Drives the memory controls for exactly one cycle per access and returns registered read data with a one-cycle done pulse.

Parameters:
ADDR_W, 9, memory byte-address width
DATA_W, 32, data width

Ports:
clk  in  1  clock; all state changes on the rising edge
rst_n  in  1  asynchronous active-low reset
r0_req  in  1  requester 0 access request; held high until r0_gnt
r0_rw  in  1  0=read, 1=write
r0_size  in  2  00=byte, 01=halfword, 10=word, 11=illegal
r0_se  in  1  sign-extend read data
r0_addr  in  ADDR_W  byte address
r0_wdata  in  DATA_W  write data, right-aligned
r0_gnt  out  1  one-cycle pulse: request accepted
r0_done  out  1  one-cycle pulse: access complete
r0_err  out  1  valid with r0_done: access rejected
r0_rdata  out  DATA_W  read data, valid from r0_done onward
r1_req, r1_rw, r1_size, r1_se, r1_addr, r1_wdata, r1_gnt, r1_done, r1_err, r1_rdata: identical to requester 0
mem_a  out  ADDR_W  memory address
mem_di  out  DATA_W  memory write data
mem_size  out  2  memory Size
mem_rw  out  1  memory RW
mem_e  out  1  memory enable
mem_se  out  1  memory SE
mem_do  in  DATA_W  memory asynchronous read data

Behaviour:
- Clock is clk; reset is asynchronous, active-low, on rst_n.
- FSM states: IDLE, ACCESS.
- Reset values:
  - state=IDLE; rr_ptr=0 (requester 0 has priority first).
  - All gnt/done/err=0; r0_rdata=r1_rdata=0.
  - Command register cleared.
  - Memory idle outputs: mem_e=0, mem_rw=0, mem_a=0, mem_di=0, mem_size=2'b10, mem_se=0.
- IDLE:
  - If any req is high at the edge: latch the winner's rw/size/se/addr/wdata into the command register, pulse the winner's gnt for the next cycle, go to ACCESS.
  - Otherwise stay in IDLE.
- Arbitration:
  - Single requester wins.
  - Both requesting: winner = rr_ptr; rr_ptr then toggles to the loser.
  - Single-requester grants set rr_ptr to the other port.
- Alignment check at grant time, computed from the latched command:
  - Error if size=11, size=01 with addr[0]=1, or size=10 with addr[1:0]!=0.
- ACCESS, one cycle:
  - Legal command: mem_a/mem_di/mem_size/mem_rw/mem_se driven from the command register, mem_e=1.
  - Illegal command: mem_e=0 and the memory-idle values are driven.
  - At the closing edge:
    - Write: the memory commits.
    - Legal read: mem_do captured into the owner's rdata.
    - Owner's done pulses for the next cycle, with err=1 if illegal.
    - Owner's rdata is unchanged on a write; set to 0 on an error.
    - Return to IDLE.
- Latency, req high to done high: 2 cycles. Throughput: one access per 2 cycles.
- Memory outputs are combinational from state and command register. mem_e is never high in IDLE.
- gnt and done are never high together for the same port.
- Requester rules:
  - Must drop req in the cycle its gnt is high.
  - May raise a new req in the cycle its done is high; it is then arbitrated in IDLE that cycle.
  - A req still high in the gnt cycle is treated as a new request after done.
- rX_rdata holds its value until that port's next read done.
- Reset asserted mid-ACCESS:
  - mem_e drops immediately, asynchronously.
  - No done is issued; the write is not guaranteed.
  - All state returns to reset values.

Test Plan:
- Reset, then r0 reads word @0x000 (memory preloaded 0x11223344): r0_gnt at cycle 1, mem_e=1/mem_rw=0/mem_size=10 for exactly 1 cycle, r0_done at cycle 2 with r0_rdata=0x11223344, r0_err=0.
- Both req same cycle after reset: r0 writes byte 0xA6 @0x000, r1 reads byte SE=1 @0x000. Required: r0 granted first; r1 granted on the cycle after r0_done; r1_rdata=0xFFFFFFA6.
- Both req held continuously for 4 accesses: grants strictly alternate r0,r1,r0,r1; no grant cycle overlaps ACCESS; mem_e high on every 2nd cycle only.
- r1 halfword @0x003, then word @0x006, then size=11: each gives r1_done with r1_err=1, mem_e never asserted, r1_rdata=0.
- r0 word write 0xABCDEF01 @0x008, then r0 halfword read @0x008 with SE=0: r0_rdata=0x0000EF01. Same read with SE=1 @0x00A gives 0xFFFFABCD.
- rst_n dropped mid-ACCESS of a read: mem_e=0 within the same cycle (asynchronous), no r0_done ever pulses, and the next request after release is granted to r0.

Source files
------------

// File: rtl/dmem_arbiter.sv
// Two-port round-robin arbiter and single-cycle access sequencer for the
// byte-addressed data memory; rejects misaligned or illegal-size accesses.
//
// state  | meaning
// IDLE   | waiting for a request; arbitrates and latches the winner's command
// ACCESS | one memory cycle for the latched command, then done/err to owner
module dmem_arbiter #(
  parameter int ADDR_W = 9,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              r0_req,
  input  logic              r0_rw,
  input  logic [1:0]        r0_size,
  input  logic              r0_se,
  input  logic [ADDR_W-1:0] r0_addr,
  input  logic [DATA_W-1:0] r0_wdata,
  output logic              r0_gnt,
  output logic              r0_done,
  output logic              r0_err,
  output logic [DATA_W-1:0] r0_rdata,
  input  logic              r1_req,
  input  logic              r1_rw,
  input  logic [1:0]        r1_size,
  input  logic              r1_se,
  input  logic [ADDR_W-1:0] r1_addr,
  input  logic [DATA_W-1:0] r1_wdata,
  output logic              r1_gnt,
  output logic              r1_done,
  output logic              r1_err,
  output logic [DATA_W-1:0] r1_rdata,
  output logic [ADDR_W-1:0] mem_a,
  output logic [DATA_W-1:0] mem_di,
  output logic [1:0]        mem_size,
  output logic              mem_rw,
  output logic              mem_e,
  output logic              mem_se,
  input  logic [DATA_W-1:0] mem_do
);

  typedef enum logic {IDLE, ACCESS} state_t;

  state_t            state, state_nxt;
  logic              grant;
  logic              win;
  logic              rr_ptr;
  logic              cmd_owner;
  logic              cmd_rw;
  logic [1:0]        cmd_size;
  logic              cmd_se;
  logic [ADDR_W-1:0] cmd_addr;
  logic [DATA_W-1:0] cmd_wdata;
  logic              cmd_err;
  logic              mem_go;

  // Contention goes to rr_ptr; a lone requester always wins.
  assign win = (r0_req && r1_req) ? rr_ptr : r1_req;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    grant     = 1'b0;
    case (state)
      IDLE: begin
        if (r0_req || r1_req) begin
          grant     = 1'b1;
          state_nxt = ACCESS;
        end
      end
      ACCESS:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    case (cmd_size)
      2'b00:   cmd_err = 1'b0;
      2'b01:   cmd_err = cmd_addr[0];
      2'b10:   cmd_err = |cmd_addr[1:0];
      default: cmd_err = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr    <= 1'b0;
      cmd_owner <= 1'b0;
      cmd_rw    <= 1'b0;
      cmd_size  <= 2'b00;
      cmd_se    <= 1'b0;
      cmd_addr  <= '0;
      cmd_wdata <= '0;
      r0_gnt    <= 1'b0;
      r1_gnt    <= 1'b0;
      r0_done   <= 1'b0;
      r1_done   <= 1'b0;
      r0_err    <= 1'b0;
      r1_err    <= 1'b0;
      r0_rdata  <= '0;
      r1_rdata  <= '0;
    end else begin
      r0_gnt  <= 1'b0;
      r1_gnt  <= 1'b0;
      r0_done <= 1'b0;
      r1_done <= 1'b0;
      r0_err  <= 1'b0;
      r1_err  <= 1'b0;
      if (grant) begin
        cmd_owner <= win;
        cmd_rw    <= win ? r1_rw    : r0_rw;
        cmd_size  <= win ? r1_size  : r0_size;
        cmd_se    <= win ? r1_se    : r0_se;
        cmd_addr  <= win ? r1_addr  : r0_addr;
        cmd_wdata <= win ? r1_wdata : r0_wdata;
        r0_gnt    <= ~win;
        r1_gnt    <= win;
        rr_ptr    <= ~win;
      end
      if (state == ACCESS) begin
        if (cmd_owner) begin
          r1_done <= 1'b1;
          r1_err  <= cmd_err;
          if (cmd_err)      r1_rdata <= '0;
          else if (!cmd_rw) r1_rdata <= mem_do;
        end else begin
          r0_done <= 1'b1;
          r0_err  <= cmd_err;
          if (cmd_err)      r0_rdata <= '0;
          else if (!cmd_rw) r0_rdata <= mem_do;
        end
      end
    end
  end

  // Rejected commands never reach the memory pins.
  assign mem_go   = (state == ACCESS) && !cmd_err;
  assign mem_e    = mem_go;
  assign mem_a    = mem_go ? cmd_addr  : '0;
  assign mem_di   = mem_go ? cmd_wdata : '0;
  assign mem_size = mem_go ? cmd_size  : 2'b10;
  assign mem_rw   = mem_go ? cmd_rw    : 1'b0;
  assign mem_se   = mem_go ? cmd_se    : 1'b0;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Scoreboard bench for dmem_arbiter: stimulus pushes expected grants and
// responses; a negedge monitor pops and compares them against the DUT.
`timescale 1ns/1ps
module tb_dmem_arbiter;
  localparam int AW = 9;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          r0_req = 1'b0, r0_rw = 1'b0, r0_se = 1'b0;
  logic [1:0]    r0_size = 2'b00;
  logic [AW-1:0] r0_addr = '0;
  logic [DW-1:0] r0_wdata = '0;
  logic          r0_gnt, r0_done, r0_err;
  logic [DW-1:0] r0_rdata;
  logic          r1_req = 1'b0, r1_rw = 1'b0, r1_se = 1'b0;
  logic [1:0]    r1_size = 2'b00;
  logic [AW-1:0] r1_addr = '0;
  logic [DW-1:0] r1_wdata = '0;
  logic          r1_gnt, r1_done, r1_err;
  logic [DW-1:0] r1_rdata;
  logic [AW-1:0] mem_a;
  logic [DW-1:0] mem_di, mem_do;
  logic [1:0]    mem_size;
  logic          mem_rw, mem_e, mem_se;

  always #5 clk = ~clk;

  dmem_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk(clk), .rst_n(rst_n),
    .r0_req(r0_req), .r0_rw(r0_rw), .r0_size(r0_size), .r0_se(r0_se),
    .r0_addr(r0_addr), .r0_wdata(r0_wdata), .r0_gnt(r0_gnt), .r0_done(r0_done),
    .r0_err(r0_err), .r0_rdata(r0_rdata),
    .r1_req(r1_req), .r1_rw(r1_rw), .r1_size(r1_size), .r1_se(r1_se),
    .r1_addr(r1_addr), .r1_wdata(r1_wdata), .r1_gnt(r1_gnt), .r1_done(r1_done),
    .r1_err(r1_err), .r1_rdata(r1_rdata),
    .mem_a(mem_a), .mem_di(mem_di), .mem_size(mem_size), .mem_rw(mem_rw),
    .mem_e(mem_e), .mem_se(mem_se), .mem_do(mem_do)
  );

  // Little-endian byte memory with asynchronous read.
  logic [7:0] mem [512];

  function automatic logic [31:0] mem_read(input logic [8:0] a, input logic [1:0] sz,
                                           input logic se);
    logic [31:0] v;
    case (sz)
      2'b00:   v = {{24{se & mem[a][7]}}, mem[a]};
      2'b01:   v = {{16{se & mem[a+9'd1][7]}}, mem[a+9'd1], mem[a]};
      default: v = {mem[a+9'd3], mem[a+9'd2], mem[a+9'd1], mem[a]};
    endcase
    return v;
  endfunction

  always_comb mem_do = mem_read(mem_a, mem_size, mem_se);

  always @(posedge clk) begin
    if (mem_e && mem_rw) begin
      mem[mem_a] <= mem_di[7:0];
      if (mem_size != 2'b00) mem[mem_a+9'd1] <= mem_di[15:8];
      if (mem_size == 2'b10) begin
        mem[mem_a+9'd2] <= mem_di[23:16];
        mem[mem_a+9'd3] <= mem_di[31:24];
      end
    end
  end

  typedef struct packed {logic err; logic [31:0] rdata;} resp_t;
  typedef struct packed {logic port; logic e; logic rw; logic [1:0] size; logic [8:0] addr;} gexp_t;

  resp_t exp_q0[$];
  resp_t exp_q1[$];
  gexp_t gnt_q[$];
  int    n_cmp = 0;
  int    n_bad = 0;

  function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
    end
  endfunction

  function automatic void fail_now(input string name);
    n_cmp++;
    n_bad++;
    $display("FAIL %s: event missing or unexpected at %0t", name, $time);
  endfunction

  function automatic void push_g(input logic p, input logic e, input logic rw,
                                 input logic [1:0] sz, input logic [8:0] a);
    gexp_t g;
    g.port = p; g.e = e; g.rw = rw; g.size = sz; g.addr = a;
    gnt_q.push_back(g);
  endfunction

  // Monitor: grants, memory strobes and done responses against the scoreboard.
  always @(negedge clk) begin
    gexp_t g;
    resp_t r;
    if (rst_n) begin
      if (r0_gnt || r1_gnt) begin
        check("gnt_exclusive", {31'd0, r0_gnt & r1_gnt}, 32'd0);
        if (gnt_q.size() == 0) fail_now("gnt_unexpected");
        else begin
          g = gnt_q.pop_front();
          check("gnt_port", {31'd0, r1_gnt}, {31'd0, g.port});
          check("mem_e", {31'd0, mem_e}, {31'd0, g.e});
          check("mem_rw", {31'd0, mem_rw}, {31'd0, g.rw});
          check("mem_size", {30'd0, mem_size}, {30'd0, g.size});
          check("mem_a", {23'd0, mem_a}, {23'd0, g.addr});
        end
      end else begin
        check("mem_e_outside_access", {31'd0, mem_e}, 32'd0);
      end
      if (r0_done) begin
        check("r0_gnt_with_done", {31'd0, r0_gnt}, 32'd0);
        if (exp_q0.size() == 0) fail_now("r0_done_unexpected");
        else begin
          r = exp_q0.pop_front();
          check("r0_err", {31'd0, r0_err}, {31'd0, r.err});
          check("r0_rdata", r0_rdata, r.rdata);
        end
      end
      if (r1_done) begin
        check("r1_gnt_with_done", {31'd0, r1_gnt}, 32'd0);
        if (exp_q1.size() == 0) fail_now("r1_done_unexpected");
        else begin
          r = exp_q1.pop_front();
          check("r1_err", {31'd0, r1_err}, {31'd0, r.err});
          check("r1_rdata", r1_rdata, r.rdata);
        end
      end
    end
  end

  // Raise a request, check grant latency, drop req in the gnt cycle and
  // return in the done cycle so the next call can re-request immediately.
  task automatic req_port(input logic p, input logic rw, input logic [1:0] sz, input logic se,
                          input logic [8:0] a, input logic [31:0] wd, input int exp_wait,
                          input logic exp_err, input logic [31:0] exp_rdata);
    int    waited = 0;
    logic  got = 1'b0;
    resp_t r;
    r.err = exp_err;
    r.rdata = exp_rdata;
    if (p) begin
      exp_q1.push_back(r);
      r1_rw = rw; r1_size = sz; r1_se = se; r1_addr = a; r1_wdata = wd; r1_req = 1'b1;
    end else begin
      exp_q0.push_back(r);
      r0_rw = rw; r0_size = sz; r0_se = se; r0_addr = a; r0_wdata = wd; r0_req = 1'b1;
    end
    while (!got && waited < 20) begin
      @(posedge clk); #1;
      waited++;
      got = p ? r1_gnt : r0_gnt;
    end
    if (p) r1_req = 1'b0;
    else   r0_req = 1'b0;
    if (!got) fail_now(p ? "r1_gnt_timeout" : "r0_gnt_timeout");
    else begin
      check(p ? "r1_gnt_latency" : "r0_gnt_latency", waited, exp_wait);
      @(posedge clk); #1;
      check(p ? "r1_done_latency" : "r0_done_latency", {31'd0, p ? r1_done : r0_done}, 32'd1);
    end
  endtask

  task automatic wait_drain();
    int n = 0;
    while ((exp_q0.size() != 0 || exp_q1.size() != 0 || gnt_q.size() != 0) && n < 20) begin
      @(negedge clk); #1;
      n++;
    end
    if (n >= 20) fail_now("drain_timeout");
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  initial begin
    int n;
    for (int i = 0; i < 512; i++) mem[i] <= 8'h00;
    mem[0] <= 8'h44; mem[1] <= 8'h33; mem[2] <= 8'h22; mem[3] <= 8'h11;
    do_reset();

    @(posedge clk); #1;
    check("rst_r0_gnt", {31'd0, r0_gnt}, 32'd0);
    check("rst_r1_done", {31'd0, r1_done}, 32'd0);
    check("rst_r0_err", {31'd0, r0_err}, 32'd0);
    check("rst_r0_rdata", r0_rdata, 32'd0);
    check("rst_r1_rdata", r1_rdata, 32'd0);
    check("rst_mem_e", {31'd0, mem_e}, 32'd0);
    check("rst_mem_size", {30'd0, mem_size}, 32'd2);
    check("rst_mem_a", {23'd0, mem_a}, 32'd0);

    // Single word read.
    push_g(1'b0, 1'b1, 1'b0, 2'b10, 9'h000);
    req_port(1'b0, 1'b0, 2'b10, 1'b0, 9'h000, 32'h0, 1, 1'b0, 32'h11223344);
    wait_drain();

    // Simultaneous requests from reset: r0 byte write, r1 signed byte read.
    do_reset();
    push_g(1'b0, 1'b1, 1'b1, 2'b00, 9'h000);
    push_g(1'b1, 1'b1, 1'b0, 2'b00, 9'h000);
    fork
      req_port(1'b0, 1'b1, 2'b00, 1'b0, 9'h000, 32'h000000A6, 1, 1'b0, 32'h0);
      req_port(1'b1, 1'b0, 2'b00, 1'b1, 9'h000, 32'h0, 3, 1'b0, 32'hFFFFFFA6);
    join
    wait_drain();

    // Continuous contention: grants alternate r0, r1, r0, r1.
    push_g(1'b0, 1'b1, 1'b0, 2'b10, 9'h000);
    push_g(1'b1, 1'b1, 1'b0, 2'b01, 9'h002);
    push_g(1'b0, 1'b1, 1'b0, 2'b00, 9'h001);
    push_g(1'b1, 1'b1, 1'b1, 2'b10, 9'h010);
    fork
      begin
        req_port(1'b0, 1'b0, 2'b10, 1'b0, 9'h000, 32'h0, 1, 1'b0, 32'h112233A6);
        req_port(1'b0, 1'b0, 2'b00, 1'b0, 9'h001, 32'h0, 3, 1'b0, 32'h00000033);
      end
      begin
        req_port(1'b1, 1'b0, 2'b01, 1'b0, 9'h002, 32'h0, 3, 1'b0, 32'h00001122);
        req_port(1'b1, 1'b1, 2'b10, 1'b0, 9'h010, 32'h55667788, 3, 1'b0, 32'h00001122);
      end
    join
    wait_drain();

    // Rejected accesses never strobe the memory and clear rdata.
    push_g(1'b1, 1'b0, 1'b0, 2'b10, 9'h000);
    push_g(1'b1, 1'b0, 1'b0, 2'b10, 9'h000);
    push_g(1'b1, 1'b0, 1'b0, 2'b10, 9'h000);
    req_port(1'b1, 1'b0, 2'b01, 1'b0, 9'h003, 32'h0, 1, 1'b1, 32'h0);
    req_port(1'b1, 1'b0, 2'b10, 1'b0, 9'h006, 32'h0, 1, 1'b1, 32'h0);
    req_port(1'b1, 1'b0, 2'b11, 1'b0, 9'h000, 32'h0, 1, 1'b1, 32'h0);
    wait_drain();

    // Word write, then halfword reads with and without sign extension.
    push_g(1'b0, 1'b1, 1'b1, 2'b10, 9'h008);
    push_g(1'b0, 1'b1, 1'b0, 2'b01, 9'h008);
    push_g(1'b0, 1'b1, 1'b0, 2'b01, 9'h00A);
    req_port(1'b0, 1'b1, 2'b10, 1'b0, 9'h008, 32'hABCDEF01, 1, 1'b0, 32'h00000033);
    req_port(1'b0, 1'b0, 2'b01, 1'b0, 9'h008, 32'h0, 1, 1'b0, 32'h0000EF01);
    req_port(1'b0, 1'b0, 2'b01, 1'b1, 9'h00A, 32'h0, 1, 1'b0, 32'hFFFFABCD);
    wait_drain();

    // Reset in the middle of an r0 read: mem_e drops at once, no done.
    r0_rw = 1'b0; r0_size = 2'b10; r0_se = 1'b0; r0_addr = 9'h000; r0_req = 1'b1;
    n = 0;
    while (!r0_gnt && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    r0_req = 1'b0;
    if (!r0_gnt) fail_now("mid_reset_gnt_timeout");
    else begin
      check("mid_reset_mem_e_before", {31'd0, mem_e}, 32'd1);
      #2 rst_n = 1'b0;
      #1 check("mid_reset_mem_e_async", {31'd0, mem_e}, 32'd0);
      check("mid_reset_gnt_cleared", {31'd0, r0_gnt}, 32'd0);
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      repeat (3) @(posedge clk);
      #1;
    end
    push_g(1'b0, 1'b1, 1'b0, 2'b10, 9'h000);
    push_g(1'b1, 1'b1, 1'b0, 2'b00, 9'h010);
    fork
      req_port(1'b0, 1'b0, 2'b10, 1'b0, 9'h000, 32'h0, 1, 1'b0, 32'h112233A6);
      req_port(1'b1, 1'b0, 2'b00, 1'b0, 9'h010, 32'h0, 3, 1'b0, 32'h00000088);
    join
    wait_drain();

    repeat (2) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
